sprite_ctrl: RTL and testbench
==============================

SPRITE_CTRL -- requirements
Module: sprite_ctrl

Interface
REQ-001 SHALL have parameter PAC_STEP, default 2, pixels Pac moves per frame tick.
REQ-002 SHALL have parameter GHOST_STEP, default 1, pixels Ghost moves per Ghost move.
REQ-003 SHALL have parameter GHOST_DIV, default 2, frame ticks between Ghost moves (1..15).
REQ-004 SHALL have ports: clk in 1 system clock; rst in 1 reset, synchronous, active-high.
REQ-005 SHALL have ports: vs in 1 VGA vertical sync, active-low, asynchronous to clk; start in 1 start/restart request, level; dir_req in 4 one-hot-ish request, bit3 up, bit2 down, bit1 left, bit0 right.
REQ-006 SHALL have ports: PacX out 10, PacY out 9, GhostX out 10, GhostY out 9 (sprite top-left pixel); state out 2 Pac facing; game_over out 1; frame_tick out 1 debug strobe.

Function
REQ-007 vs SHALL pass a 2-flop synchronizer; frame_tick SHALL pulse exactly one cycle on each synchronized 1->0 transition.
REQ-008 FSM states IDLE, PLAY, DEAD; IDLE->PLAY on start; PLAY->DEAD on collision; DEAD->IDLE on start; no other transitions.
REQ-009 Entering IDLE (reset or from DEAD) SHALL load Pac (304,224), Ghost (0,0), state 2'b10, Ghost divider 0.
REQ-010 In IDLE and DEAD, positions, state and divider SHALL hold.
REQ-011 state encoding: 00 up, 01 down, 10 right, 11 left.
REQ-012 In PLAY, any cycle with dir_req != 0 SHALL update state next cycle; priority up>down>left>right; dir_req == 0 holds state.
REQ-013 In PLAY on frame_tick, Pac SHALL move PAC_STEP in the current state direction, using state as registered before that cycle.
REQ-014 Pac SHALL clamp: X in [0,608], Y in [0,448]; a step crossing a bound lands exactly on the bound, no wrap.
REQ-015 Ghost divider SHALL count frame ticks in PLAY; on reaching GHOST_DIV-1 it resets to 0 and Ghost moves that tick.
REQ-016 Ghost move: dx = PacX-GhostX, dy = PacY-GhostY, 11-bit signed, using pre-tick positions; step GHOST_STEP along the axis with larger |d|; tie -> X axis; both zero -> no move; clamped as REQ-014; never overshoots Pac (step = min(GHOST_STEP,|d|)).
REQ-017 Collision SHALL be |dx|<32 AND |dy|<32, evaluated on post-move positions in the same tick; the transition to DEAD and game_over=1 occur on the cycle after that tick.
REQ-018 game_over SHALL be 1 exactly while in DEAD.
REQ-019 start and frame_tick in the same IDLE cycle: enter PLAY, no movement on that tick.
REQ-020 start while in PLAY SHALL be ignored.
REQ-021 All outputs SHALL be registered; positions change only on the cycle after frame_tick, i.e. during vertical blanking.

Reset
REQ-022 rst SHALL force IDLE, Pac (304,224), Ghost (0,0), state 2'b10, game_over 0, frame_tick 0, and clear the synchronizer to 1s so no spurious tick occurs.
REQ-023 rst mid-frame or in DEAD SHALL take effect the next clk edge, with no move pending after release.

Structure
REQ-024 Shared package pacman_pkg SHALL hold the direction encoding, FSM state encoding, SPRITE=32, X_MAX=608, Y_MAX=448, and the Pac/Ghost start coordinates.
REQ-025 The vs synchronizer and edge detector SHALL be sub-module frame_tick_gen; movement and FSM stay in sprite_ctrl.

Verification
REQ-026 Reset, start, 10 vs pulses, dir_req=0 -> PacX 304->324, PacY 224, state 10.
REQ-027 PacX 606, state 10, one tick -> PacX 608; next tick -> stays 608; dir_req=1000 at PacY 1, tick -> PacY 0.
REQ-028 Pac (304,224), Ghost (0,0), GHOST_DIV 2, 4 ticks with Pac held by clamp or test force -> Ghost moves on ticks 2 and 4 along X only, GhostX=2.
REQ-029 Ghost (270,224), Pac (304,224), state 11, tick -> PacX 302, collision; next cycle game_over=1, positions frozen over 3 further ticks.
REQ-030 In DEAD assert start -> IDLE, positions reloaded to start values; start plus simultaneous frame_tick in IDLE -> PLAY, no move that tick.
REQ-031 dir_req=1111 in PLAY -> state 00; rst asserted during PLAY between ticks -> all REQ-022 values next cycle.

Source files
------------

// File: rtl/pacman_pkg.sv
// Shared encodings and playfield geometry for the Pac/Ghost sprite controller.
package pacman_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_DOWN  = 2'b01,
        DIR_RIGHT = 2'b10,
        DIR_LEFT  = 2'b11
    } dir_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PLAY = 2'b01,
        ST_DEAD = 2'b10
    } fsm_e;

    localparam int SPRITE = 32;
    localparam int X_MAX  = 608;
    localparam int Y_MAX  = 448;

    localparam logic [9:0] PAC_X0   = 10'd304;
    localparam logic [8:0] PAC_Y0   = 9'd224;
    localparam logic [9:0] GHOST_X0 = 10'd0;
    localparam logic [8:0] GHOST_Y0 = 9'd0;

    // Up wins over down, down over left, left over right.
    function automatic dir_e dir_from_req(input logic [3:0] req);
        if (req[3]) return DIR_UP;
        if (req[2]) return DIR_DOWN;
        if (req[1]) return DIR_LEFT;
        return DIR_RIGHT;
    endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// Brings the asynchronous active-low vsync into the clk domain and emits a
// registered one-cycle strobe on every falling edge.
module frame_tick_gen
    import pacman_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic vs,
    output logic frame_tick
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;
    logic tick_q;
    logic tick_d;

    always_comb begin
        tick_d = prev_q & ~sync2_q;
    end

    // Synchronizer resets high so a low vs at release is seen as a real edge only once.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
            tick_q  <= 1'b0;
        end else begin
            sync1_q <= vs;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            tick_q  <= tick_d;
        end
    end

    assign frame_tick = tick_q;

endmodule

// File: rtl/sprite_ctrl.sv
// Pac/Ghost movement, chase logic and game FSM, stepped once per video frame.
module sprite_ctrl
    import pacman_pkg::*;
#(
    parameter int PAC_STEP   = 2,
    parameter int GHOST_STEP = 1,
    parameter int GHOST_DIV  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       vs,
    input  logic       start,
    input  logic [3:0] dir_req,
    output logic [9:0] PacX,
    output logic [8:0] PacY,
    output logic [9:0] GhostX,
    output logic [8:0] GhostY,
    output logic [1:0] state,
    output logic       game_over,
    output logic       frame_tick
);

    localparam logic [9:0]  PAC_STEP_X = 10'(PAC_STEP);
    localparam logic [8:0]  PAC_STEP_Y = 9'(PAC_STEP);
    localparam logic [9:0]  G_STEP_X   = 10'(GHOST_STEP);
    localparam logic [8:0]  G_STEP_Y   = 9'(GHOST_STEP);
    localparam logic [10:0] G_STEP_W   = 11'(GHOST_STEP);
    localparam logic [3:0]  DIV_LAST   = 4'(GHOST_DIV - 1);
    localparam logic [10:0] HIT_DIST   = 11'(SPRITE);

    function automatic logic [9:0] step_x(input logic [9:0] pos, input logic [9:0] step,
                                          input logic dec);
        logic [10:0] sum;
        sum = {1'b0, pos} + {1'b0, step};
        if (dec) return (pos < step) ? 10'd0 : pos - step;
        return (sum > 11'(X_MAX)) ? 10'(X_MAX) : sum[9:0];
    endfunction

    function automatic logic [8:0] step_y(input logic [8:0] pos, input logic [8:0] step,
                                         input logic dec);
        logic [9:0] sum;
        sum = {1'b0, pos} + {1'b0, step};
        if (dec) return (pos < step) ? 9'd0 : pos - step;
        return (sum > 10'(Y_MAX)) ? 9'(Y_MAX) : sum[8:0];
    endfunction

    function automatic logic [10:0] abs11(input logic signed [10:0] d);
        return d[10] ? -d : d;
    endfunction

    fsm_e        fsm_q, fsm_d;
    dir_e        dir_q, dir_d;
    logic [9:0]  pac_x_q, pac_x_d, ghost_x_q, ghost_x_d;
    logic [8:0]  pac_y_q, pac_y_d, ghost_y_q, ghost_y_d;
    logic [3:0]  div_q, div_d;
    logic        game_over_q, game_over_d;

    logic signed [10:0] dx, dy, cdx, cdy;
    logic [10:0] adx, ady;
    logic [9:0]  gstep_x;
    logic [8:0]  gstep_y;
    logic        ghost_move;

    frame_tick_gen u_tick (
        .clk        (clk),
        .rst        (rst),
        .vs         (vs),
        .frame_tick (frame_tick)
    );

    // Chase distances use the positions held before this tick.
    assign dx      = $signed({1'b0, pac_x_q}) - $signed({1'b0, ghost_x_q});
    assign dy      = $signed({2'b0, pac_y_q}) - $signed({2'b0, ghost_y_q});
    assign adx     = abs11(dx);
    assign ady     = abs11(dy);
    assign gstep_x = (adx < G_STEP_W) ? adx[9:0] : G_STEP_X;
    assign gstep_y = (ady < G_STEP_W) ? ady[8:0] : G_STEP_Y;

    always_comb begin
        fsm_d      = fsm_q;
        dir_d      = dir_q;
        pac_x_d    = pac_x_q;
        pac_y_d    = pac_y_q;
        ghost_x_d  = ghost_x_q;
        ghost_y_d  = ghost_y_q;
        div_d      = div_q;
        ghost_move = 1'b0;
        cdx        = '0;
        cdy        = '0;
        case (fsm_q)
            ST_IDLE: begin
                if (start) fsm_d = ST_PLAY;
            end
            ST_PLAY: begin
                if (dir_req != 4'b0000) dir_d = dir_from_req(dir_req);
                if (frame_tick) begin
                    case (dir_q)
                        DIR_UP:    pac_y_d = step_y(pac_y_q, PAC_STEP_Y, 1'b1);
                        DIR_DOWN:  pac_y_d = step_y(pac_y_q, PAC_STEP_Y, 1'b0);
                        DIR_RIGHT: pac_x_d = step_x(pac_x_q, PAC_STEP_X, 1'b0);
                        DIR_LEFT:  pac_x_d = step_x(pac_x_q, PAC_STEP_X, 1'b1);
                    endcase
                    if (div_q == DIV_LAST) begin
                        div_d      = 4'd0;
                        ghost_move = 1'b1;
                    end else begin
                        div_d = div_q + 4'd1;
                    end
                    // Ties go to X; the step is trimmed so the ghost never passes Pac.
                    if (ghost_move && (adx != 11'd0 || ady != 11'd0)) begin
                        if (adx >= ady) ghost_x_d = step_x(ghost_x_q, gstep_x, dx[10]);
                        else            ghost_y_d = step_y(ghost_y_q, gstep_y, dy[10]);
                    end
                    cdx = $signed({1'b0, pac_x_d}) - $signed({1'b0, ghost_x_d});
                    cdy = $signed({2'b0, pac_y_d}) - $signed({2'b0, ghost_y_d});
                    if (abs11(cdx) < HIT_DIST && abs11(cdy) < HIT_DIST) fsm_d = ST_DEAD;
                end
            end
            ST_DEAD: begin
                if (start) begin
                    fsm_d     = ST_IDLE;
                    dir_d     = DIR_RIGHT;
                    pac_x_d   = PAC_X0;
                    pac_y_d   = PAC_Y0;
                    ghost_x_d = GHOST_X0;
                    ghost_y_d = GHOST_Y0;
                    div_d     = 4'd0;
                end
            end
            default: fsm_d = ST_IDLE;
        endcase
        game_over_d = (fsm_d == ST_DEAD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q       <= ST_IDLE;
            dir_q       <= DIR_RIGHT;
            pac_x_q     <= PAC_X0;
            pac_y_q     <= PAC_Y0;
            ghost_x_q   <= GHOST_X0;
            ghost_y_q   <= GHOST_Y0;
            div_q       <= 4'd0;
            game_over_q <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            dir_q       <= dir_d;
            pac_x_q     <= pac_x_d;
            pac_y_q     <= pac_y_d;
            ghost_x_q   <= ghost_x_d;
            ghost_y_q   <= ghost_y_d;
            div_q       <= div_d;
            game_over_q <= game_over_d;
        end
    end

    assign PacX      = pac_x_q;
    assign PacY      = pac_y_q;
    assign GhostX    = ghost_x_q;
    assign GhostY    = ghost_y_q;
    assign state     = dir_q;
    assign game_over = game_over_q;

endmodule

// File: tb/tb_sprite_ctrl.sv
// Scoreboard bench: two parameterisations driven in lockstep against a frame-level game model.
module tb_sprite_ctrl;

    logic       clk = 1'b0;
    logic       rst, vs, start;
    logic [3:0] dir_req;
    logic [9:0] px0, gx0, px1, gx1;
    logic [8:0] py0, gy0, py1, gy1;
    logic [1:0] st0, st1;
    logic       go0, go1, ft0, ft1;

    sprite_ctrl #(.PAC_STEP(2), .GHOST_STEP(1), .GHOST_DIV(2)) u_dut0 (
        .clk(clk), .rst(rst), .vs(vs), .start(start), .dir_req(dir_req),
        .PacX(px0), .PacY(py0), .GhostX(gx0), .GhostY(gy0),
        .state(st0), .game_over(go0), .frame_tick(ft0)
    );

    sprite_ctrl #(.PAC_STEP(3), .GHOST_STEP(2), .GHOST_DIV(3)) u_dut1 (
        .clk(clk), .rst(rst), .vs(vs), .start(start), .dir_req(dir_req),
        .PacX(px1), .PacY(py1), .GhostX(gx1), .GhostY(gy1),
        .state(st1), .game_over(go1), .frame_tick(ft1)
    );

    always #5 clk = ~clk;

    typedef struct {
        int px, py, gx, gy, st, go;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    int m_px[2], m_py[2], m_gx[2], m_gy[2], m_st[2], m_fsm[2], m_div[2];
    int p_step[2] = '{2, 3};
    int g_step[2] = '{1, 2};
    int g_div[2]  = '{2, 3};

    task automatic chk(input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int clampv(input int v, input int hi);
        if (v < 0) return 0;
        if (v > hi) return hi;
        return v;
    endfunction

    task automatic model_reset(input int i);
        m_px[i] = 304; m_py[i] = 224; m_gx[i] = 0; m_gy[i] = 0;
        m_st[i] = 2; m_fsm[i] = 0; m_div[i] = 0;
    endtask

    task automatic model_start(input int i);
        if (m_fsm[i] == 0) m_fsm[i] = 1;
        else if (m_fsm[i] == 2) model_reset(i);
    endtask

    task automatic model_dir(input int i, input logic [3:0] v);
        if (m_fsm[i] == 1 && v != 4'b0000)
            m_st[i] = v[3] ? 0 : v[2] ? 1 : v[1] ? 3 : 2;
    endtask

    task automatic model_tick(input int i);
        int opx, opy, ogx, ogy, dx, dy, s;
        if (m_fsm[i] != 1) return;
        opx = m_px[i]; opy = m_py[i]; ogx = m_gx[i]; ogy = m_gy[i];
        case (m_st[i])
            0: m_py[i] = clampv(opy - p_step[i], 448);
            1: m_py[i] = clampv(opy + p_step[i], 448);
            2: m_px[i] = clampv(opx + p_step[i], 608);
            default: m_px[i] = clampv(opx - p_step[i], 608);
        endcase
        if (m_div[i] == g_div[i] - 1) begin
            m_div[i] = 0;
            dx = opx - ogx;
            dy = opy - ogy;
            if (dx != 0 || dy != 0) begin
                if (iabs(dx) >= iabs(dy)) begin
                    s = (iabs(dx) < g_step[i]) ? iabs(dx) : g_step[i];
                    m_gx[i] = clampv(ogx + ((dx > 0) ? s : -s), 608);
                end else begin
                    s = (iabs(dy) < g_step[i]) ? iabs(dy) : g_step[i];
                    m_gy[i] = clampv(ogy + ((dy > 0) ? s : -s), 448);
                end
            end
        end else begin
            m_div[i]++;
        end
        if (iabs(m_px[i] - m_gx[i]) < 32 && iabs(m_py[i] - m_gy[i]) < 32) m_fsm[i] = 2;
    endtask

    task automatic push_exp();
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            e.px = m_px[i]; e.py = m_py[i]; e.gx = m_gx[i]; e.gy = m_gy[i];
            e.st = m_st[i]; e.go = (m_fsm[i] == 2) ? 1 : 0;
            sb_q.push_back(e);
        end
    endtask

    task automatic cmp6(input string tag, input exp_t e, input int px, input int py,
                        input int gx, input int gy, input int st, input int go);
        chk({tag, ".PacX"}, px, e.px);
        chk({tag, ".PacY"}, py, e.py);
        chk({tag, ".GhostX"}, gx, e.gx);
        chk({tag, ".GhostY"}, gy, e.gy);
        chk({tag, ".state"}, st, e.st);
        chk({tag, ".game_over"}, go, e.go);
    endtask

    task automatic compare(input string tag);
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            if (sb_q.size() == 0) begin
                chk({tag, ".sb_empty"}, 0, 1);
                return;
            end
            e = sb_q.pop_front();
            if (i == 0) cmp6({tag, ".u0"}, e, px0, py0, gx0, gy0, st0, go0);
            else        cmp6({tag, ".u1"}, e, px1, py1, gx1, gy1, st1, go1);
        end
    endtask

    task automatic tick(input bit with_start, input string tag);
        bit found = 1'b0;
        @(negedge clk);
        vs = 1'b0;
        for (int k = 0; k < 8 && !found; k++) begin
            @(posedge clk);
            #1;
            if (ft0 && ft1) found = 1'b1;
        end
        if (!found) chk({tag, ".tick_timeout"}, 0, 1);
        if (with_start) start = 1'b1;
        for (int i = 0; i < 2; i++) begin
            if (m_fsm[i] == 1) model_tick(i);
            else if (with_start) model_start(i);
        end
        push_exp();
        @(posedge clk);
        #1;
        start = 1'b0;
        compare(tag);
        chk({tag, ".tick_width"}, ft0, 0);
        vs = 1'b1;
        repeat (4) @(posedge clk);
    endtask

    task automatic set_dir(input logic [3:0] v, input string tag);
        @(negedge clk);
        dir_req = v;
        for (int i = 0; i < 2; i++) model_dir(i, v);
        push_exp();
        @(posedge clk);
        #1;
        compare(tag);
        dir_req = 4'b0000;
    endtask

    task automatic do_start(input string tag);
        @(negedge clk);
        start = 1'b1;
        for (int i = 0; i < 2; i++) model_start(i);
        push_exp();
        @(posedge clk);
        #1;
        compare(tag);
        start = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst = 1'b1;
        vs  = 1'b0;
        for (int i = 0; i < 2; i++) model_reset(i);
        push_exp();
        @(posedge clk);
        #1;
        compare(tag);
        chk({tag, ".frame_tick"}, ft0, 0);
        chk({tag, ".PacX_abs"}, px0, 304);
        chk({tag, ".game_over_abs"}, go0, 0);
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        push_exp();
        compare({tag, "_hold"});
        vs = 1'b1;
        repeat (4) @(posedge clk);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; vs = 1'b1; start = 1'b0; dir_req = 4'b0000;
        for (int i = 0; i < 2; i++) model_reset(i);
        repeat (3) @(posedge clk);
        #1;
        push_exp();
        compare("reset");
        chk("reset.frame_tick", ft0, 0);
        chk("reset.state_abs", st0, 2);
        @(negedge clk);
        rst = 1'b0;

        tick(1'b0, "idle");
        tick(1'b0, "idle");
        tick(1'b1, "start_tick");

        repeat (10) tick(1'b0, "run_r");
        chk("ten_ticks.PacX", px0, 324);
        chk("ten_ticks.PacY", py0, 224);
        chk("ten_ticks.state", st0, 2);

        repeat (141) tick(1'b0, "run_r");
        chk("edge.PacX606", px0, 606);
        tick(1'b0, "clamp_r");
        chk("clamp_r.PacX", px0, 608);
        tick(1'b0, "clamp_r2");
        chk("clamp_r2.PacX", px0, 608);
        chk("clamp_r2.PacX_u1", px1, 608);

        set_dir(4'b1000, "dir_up");
        chk("dir_up.state", st0, 0);
        repeat (114) tick(1'b0, "run_up");
        chk("clamp_up.PacY", py0, 0);
        chk("clamp_up.PacY_u1", py1, 0);

        set_dir(4'b0110, "prio_down");
        chk("prio_down.state", st0, 1);
        set_dir(4'b0011, "prio_left");
        chk("prio_left.state", st0, 3);
        set_dir(4'b0001, "prio_right");
        chk("prio_right.state", st0, 2);
        set_dir(4'b1111, "prio_all");
        chk("prio_all.state", st0, 0);
        set_dir(4'b0010, "go_left");

        for (int k = 0; k < 400 && !(m_fsm[0] == 2 && m_fsm[1] == 2); k++)
            tick(1'b0, "chase1");
        chk("chase1.dead_u0", go0, 1);
        chk("chase1.dead_u1", go1, 1);
        repeat (3) tick(1'b0, "frozen");

        do_start("dead_start");
        chk("reload.PacX", px0, 304);
        chk("reload.PacY", py0, 224);
        chk("reload.GhostX", gx0, 0);
        chk("reload.GhostY", gy0, 0);
        chk("reload.state", st0, 2);
        chk("reload.game_over", go0, 0);
        tick(1'b1, "restart_tick");
        chk("restart_tick.PacX", px0, 304);

        set_dir(4'b0010, "left2");
        repeat (3) tick(1'b0, "run_l");
        do_start("play_start_ignored");
        do_reset("rst_play");

        tick(1'b1, "start3");
        set_dir(4'b0010, "left3");
        for (int k = 0; k < 1500 && !(m_fsm[0] == 2 && m_fsm[1] == 2); k++)
            tick(1'b0, "chase2");
        chk("chase2.dead_u0", go0, 1);
        chk("chase2.dead_u1", go1, 1);
        chk("chase2.PacX_u0", px0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
